reloj_soc_nios_ii_cpu_div_cell: RTL and testbench

Iterative 32-bit radix-2 restoring divider for the Nios II custom execute path. It is the inverse-operation companion to the pipelined multiplier cell. It accepts E_src1 (dividend) and E_src2 (divisor) with a start pulse and produces quotient and remainder after a fixed multicycle latency. It sits beside the multiplier in the E/M stage and stalls the pipeline via busy.

---
 rtl/reloj_soc_nios_ii_cpu_div_cell.sv | 103 ++++++++++
 tb/tb_reloj_soc_nios_ii_cpu_div_cell.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/reloj_soc_nios_ii_cpu_div_cell.sv
// Iterative radix-2 restoring divider for the Nios II execute path.
// One quotient bit per clock, with a fixed latency that does not depend on the operands.
module reloj_soc_nios_ii_cpu_div_cell #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] E_src1,
  input  logic [DATA_WIDTH-1:0] E_src2,
  input  logic                  E_div_signed,
  input  logic                  E_div_start,
  input  logic                  E_div_abort,
  output logic                  M_div_busy,
  output logic                  M_div_valid,
  output logic [DATA_WIDTH-1:0] M_div_quot,
  output logic [DATA_WIDTH-1:0] M_div_rem,
  output logic                  M_div_by_zero
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [W-1:0]  rem, quot, dvsr;
  logic          quot_neg, rem_neg, zero;
  logic [W:0]    rem_sh, trial;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? -x : x;
  endfunction

  assign rem_sh     = {rem, quot[W-1]};
  assign trial      = rem_sh - {1'b0, dvsr};
  assign M_div_busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (E_div_start) state_nxt = CALC;
      CALC: if (count == LAST) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (E_div_abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count         <= '0;
      rem           <= '0;
      quot          <= '0;
      dvsr          <= '0;
      quot_neg      <= 1'b0;
      rem_neg       <= 1'b0;
      zero          <= 1'b0;
      M_div_valid   <= 1'b0;
      M_div_quot    <= '0;
      M_div_rem     <= '0;
      M_div_by_zero <= 1'b0;
    end else begin
      M_div_valid <= 1'b0;
      if (!E_div_abort) begin
        case (state)
          IDLE: if (E_div_start) begin
            count    <= '0;
            rem      <= '0;
            quot     <= mag(E_src1, E_div_signed);
            dvsr     <= mag(E_src2, E_div_signed);
            quot_neg <= E_div_signed & (E_src1[W-1] ^ E_src2[W-1]);
            rem_neg  <= E_div_signed & E_src1[W-1];
            zero     <= (E_src2 == '0);
          end
          CALC: begin
            count <= count + 1'b1;
            if (!trial[W]) begin
              rem  <= trial[W-1:0];
              quot <= {quot[W-2:0], 1'b1};
            end else begin
              rem  <= rem_sh[W-1:0];
              quot <= {quot[W-2:0], 1'b0};
            end
          end
          FIX: begin
            // With a zero divisor every trial succeeds, so rem ends holding |dividend|;
            // the normal sign fix-up then restores the original dividend.
            M_div_quot    <= zero ? '1 : (quot_neg ? -quot : quot);
            M_div_rem     <= rem_neg ? -rem : rem;
            M_div_by_zero <= zero;
            M_div_valid   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_reloj_soc_nios_ii_cpu_div_cell.sv
// Scoreboard bench for the iterative divider: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever the valid pulse appears.
module tb_reloj_soc_nios_ii_cpu_div_cell;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] E_src1 = '0, E_src2 = '0;
  logic        E_div_signed = 1'b0, E_div_start = 1'b0, E_div_abort = 1'b0;
  logic        M_div_busy, M_div_valid, M_div_by_zero;
  logic [31:0] M_div_quot, M_div_rem;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        bz;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  reloj_soc_nios_ii_cpu_div_cell #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .E_src1(E_src1), .E_src2(E_src2), .E_div_signed(E_div_signed),
    .E_div_start(E_div_start), .E_div_abort(E_div_abort),
    .M_div_busy(M_div_busy), .M_div_valid(M_div_valid),
    .M_div_quot(M_div_quot), .M_div_rem(M_div_rem), .M_div_by_zero(M_div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // monitor
  always @(negedge clk) begin
    if (!reset_n) run = 0;
    else begin
      if (M_div_valid) begin
        if (sb.size() == 0) chk("unexpected_valid", 32'(M_div_valid), 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("quot", M_div_quot, e.q);
          chk("rem", M_div_rem, e.r);
          chk("by_zero", 32'(M_div_by_zero), 32'(e.bz));
          chk("latency", cyc, e.cyc);
          chk("busy_cycles", run, 33);
          chk("busy_at_valid", 32'(M_div_busy), 32'd0);
        end
      end
      if (M_div_busy) run++;
      else run = 0;
    end
  end

  // Called at a negedge; the start is sampled on the following posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic [31:0] eq, input logic [31:0] er, input logic ebz);
    exp_t e;
    E_src1 = a; E_src2 = b; E_div_signed = sgn; E_div_start = 1'b1;
    e.q = eq; e.r = er; e.bz = ebz; e.cyc = cyc + 34;
    sb.push_back(e);
    @(negedge clk);
    E_div_start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!M_div_valid && n < 60);
    chk("valid_seen", 32'(M_div_valid), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(M_div_busy), 32'd0);
    chk("rst_valid", 32'(M_div_valid), 32'd0);
    chk("rst_quot", M_div_quot, 32'd0);
    chk("rst_rem", M_div_rem, 32'd0);
    chk("rst_bz", 32'(M_div_by_zero), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    wait_valid();
    issue(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    wait_valid();
    issue(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0);
    wait_valid();
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
    wait_valid();
    issue(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0);
    wait_valid();
    issue(32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    wait_valid();

    // Abort at cycle 10, with an ignored start at cycle 5
    E_src1 = 32'd50; E_src2 = 32'd3; E_div_signed = 1'b0; E_div_start = 1'b1;
    @(negedge clk); E_div_start = 1'b0;
    repeat (4) @(negedge clk);
    E_src1 = 32'd9; E_src2 = 32'd9; E_div_start = 1'b1;
    @(negedge clk); E_div_start = 1'b0;
    repeat (4) @(negedge clk);
    E_div_abort = 1'b1;
    @(negedge clk); E_div_abort = 1'b0;
    chk("abort_busy", 32'(M_div_busy), 32'd0);
    chk("abort_quot_held", M_div_quot, 32'hFFFFFFFF);
    chk("abort_rem_held", M_div_rem, 32'h12345678);
    chk("abort_bz_held", 32'(M_div_by_zero), 32'd1);
    repeat (40) @(negedge clk);

    // Abort together with start in IDLE: start ignored
    E_div_start = 1'b1; E_div_abort = 1'b1;
    @(negedge clk); E_div_start = 1'b0; E_div_abort = 1'b0;
    chk("abort_start_idle", 32'(M_div_busy), 32'd0);
    repeat (2) @(negedge clk);

    // Back-to-back: second start in the valid cycle
    issue(32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 1'b0);
    wait_valid();
    issue(32'd81, 32'd9, 1'b1, 32'd9, 32'd0, 1'b0);
    wait_valid();

    // Async reset mid-CALC
    E_src1 = 32'd1000; E_src2 = 32'd3; E_div_signed = 1'b0; E_div_start = 1'b1;
    @(negedge clk); E_div_start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(M_div_busy), 32'd0);
    chk("arst_quot", M_div_quot, 32'd0);
    chk("arst_rem", M_div_rem, 32'd0);
    chk("arst_bz", 32'(M_div_by_zero), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    issue(32'hFFFFFF9C, 32'd10, 1'b1, 32'hFFFFFFF6, 32'd0, 1'b0);
    wait_valid();
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
